button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_pkg.sv | 13 +
 rtl/button_debouncer.sv | 106 ++++++++++
 tb/tb_button_debouncer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: the two-bit state encodings.
package button_debouncer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Debounces an already-synchronized level: the output follows only after
// STABLE_CYCLES consecutive samples of the new value, with one-cycle edge pulses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_signal,
  output logic debounced,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   DIRECT   = (STABLE_CYCLES == 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 deb_q, deb_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state; any pending count not explicitly carried forward drops to zero
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync_signal) begin
          if (DIRECT) begin
            state_d = STABLE_HI;
            deb_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PEND_HI: begin
        if (!sync_signal) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          deb_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_signal) begin
          if (DIRECT) begin
            state_d = STABLE_LO;
            deb_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PEND_LO: begin
        if (sync_signal) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          deb_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

  assign debounced  = deb_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Checks a 4-cycle debouncer against a hand-derived vector table and a
// 1-cycle debouncer against a delayed-input model, both through a scoreboard.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic sig4, sig1;
  logic deb4, rise4, fall4;
  logic deb1, rise1, fall1;

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .sync_signal(sig4),
    .debounced(deb4), .rise_pulse(rise4), .fall_pulse(fall4)
  );

  button_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .sync_signal(sig1),
    .debounced(deb1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  typedef struct packed {
    logic       rst;
    logic       sig;
    logic [2:0] exp;   // {debounced, rise_pulse, fall_pulse} after the edge
  } vec_t;

  typedef struct packed {
    logic [2:0] exp4;
    logic [2:0] exp1;
    int         idx;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev1    = 1'b0;

  task automatic check(input string name, input int idx, input logic [2:0] act,
                       input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got {deb,rise,fall}=%b expected %b", name, idx, act, exp);
  endtask

  // Drive one sample at negedge, queue expectations, compare after the posedge
  task automatic step(input int idx, input logic r, input logic s4, input logic [2:0] e4);
    sb_t  e;
    logic s1;
    @(negedge clk);
    s1   = 1'($urandom_range(0, 1));
    rst  = r;
    sig4 = s4;
    sig1 = s1;
    e.exp4 = e4;
    e.idx  = idx;
    if (r) begin
      e.exp1 = 3'b000;
      prev1  = 1'b0;
    end else begin
      e.exp1 = {s1, s1 & ~prev1, ~s1 & prev1};
      prev1  = s1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard step %0d: queue empty", idx);
    end else begin
      e = sb_q.pop_front();
      check("sc4", e.idx, {deb4, rise4, fall4}, e.exp4);
      check("sc1", e.idx, {deb1, rise1, fall1}, e.exp1);
    end
  endtask

  initial begin
    vec_t tbl[$];
    rst  = 1'b1;
    sig4 = 1'b0;
    sig1 = 1'b0;

    // Reset held two cycles, then idle low
    tbl.push_back('{1'b1, 1'b0, 3'b000});
    tbl.push_back('{1'b1, 1'b0, 3'b000});
    tbl.push_back('{1'b0, 1'b0, 3'b000});
    // Clean rise: commit on the 4th sampled high, then hold without pulses
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b110});
    tbl.push_back('{1'b0, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 1'b1, 3'b100});
    // Fall pattern 0,0,1,0,0,0,0: glitch restarts count, fall on the 7th edge
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b001});
    tbl.push_back('{1'b0, 1'b0, 3'b000});
    // High for 3 then low: rejected; then high for 4: rise
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b0, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b110});
    // Reset while debounced=1: drops without fall pulse, then full requalify
    tbl.push_back('{1'b1, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b110});
    // Back to low
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 1'b0, 3'b001});
    // Reset in PEND_HI at cnt=2: count discarded, rise 4 edges after reset
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b1, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 1'b1, 3'b110});

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i].rst, tbl[i].sig, tbl[i].exp);

    // Alternating glitch train from debounced=1 never qualifies a fall
    for (int i = 0; i < 12; i++) step(100 + i, 1'b0, 1'(i % 2 == 0 ? 0 : 1), 3'b100);
    // Three lows, one high, three lows: still no commit
    for (int i = 0; i < 7; i++) step(200 + i, 1'b0, 1'(i == 3), 3'b100);
    // Fourth consecutive low finally commits
    step(207, 1'b0, 1'b0, 3'b001);
    // Long low hold after commit: no pulses
    for (int i = 0; i < 8; i++) step(300 + i, 1'b0, 1'b0, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
